trivium_host_ctrl: RTL and testbench

- Host-side driver for the Trivium cipher core.
- Takes a key and a plaintext byte stream from the system side and performs the core's load sequence: serial key shift on KEY/STB_KEY, then byte pushes on DATA/STB_DATA.
- Polls SIGN_REG, pulses READ, and returns each ciphertext byte through a valid/ready output.
- Replaces the bench-only stimulus with a synthesizable initiator.

---
 rtl/trivium_host_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_trivium_host_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_host_ctrl.sv
// Host-side initiator for the Trivium core: serial key load, byte push, status poll and result read.
// Optional watchdog and ERR state are enabled by defining TRV_HOST_TIMEOUT_EN.
module trivium_host_ctrl #(
  parameter int KEY_W = 80,
  parameter int LEN_W = 16,
  parameter int TMO_W = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [7:0]       pt_data,
  input  logic             pt_valid,
  output logic             pt_ready,
  output logic [7:0]       ct_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             KEY,
  output logic             STB_KEY,
  output logic [7:0]       DATA,
  output logic             STB_DATA,
  output logic             READ,
  input  logic [7:0]       DATA_OUT,
  input  logic [7:0]       SIGN_REG
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_KEY  = 3'd1,
    WAIT_INIT = 3'd2,
    SEND      = 3'd3,
    WAIT_RES  = 3'd4,
    OUT       = 3'd5
`ifdef TRV_HOST_TIMEOUT_EN
    , ERR     = 3'd6
`endif
  } state_e;

  localparam int               CNT_W    = $clog2(KEY_W);
  localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_W - 1);

  state_e           state_q;
  logic [KEY_W-1:0] key_sr_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [LEN_W-1:0] rem_q;
  logic [7:0]       data_q;
  logic [7:0]       ct_data_q;
  logic             key_q;
  logic             stb_key_q;
  logic             stb_data_q;
  logic             read_q;
  logic             pt_ready_q;
  logic             ct_valid_q;
  logic             busy_q;
  logic             done_q;
  logic             start_ok;

  // Status bits 7:2 carry nothing this initiator acts on.
  logic [5:0] sign_unused;
  assign sign_unused = SIGN_REG[7:2];

`ifdef TRV_HOST_TIMEOUT_EN
  // The watchdog fires on the edge where the counter would reach all-ones.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
`else
  logic [TMO_W-1:0] tmo_unused;
  assign tmo_unused = '0;
`endif

  always_comb begin
    start_ok = start && (state_q == IDLE);
`ifdef TRV_HOST_TIMEOUT_EN
    if (state_q == ERR) start_ok = start;
`endif
  end

  // NOTE: asynchronous reset clears every output register, so an abort leaves no strobe behind.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      key_sr_q   <= '0;
      bit_cnt_q  <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      ct_data_q  <= '0;
      key_q      <= 1'b0;
      stb_key_q  <= 1'b0;
      stb_data_q <= 1'b0;
      read_q     <= 1'b0;
      pt_ready_q <= 1'b0;
      ct_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TRV_HOST_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      // NOTE: one-cycle strobes default low here; only the state that fires them overrides.
      stb_data_q <= 1'b0;
      read_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef TRV_HOST_TIMEOUT_EN
      tmo_q      <= '0;
`endif
      if (start_ok) begin
        state_q   <= LOAD_KEY;
        busy_q    <= 1'b1;
        stb_key_q <= 1'b1;
        key_q     <= key_in[KEY_W-1];
        key_sr_q  <= {key_in[KEY_W-2:0], 1'b0};
        bit_cnt_q <= KEY_LAST;
        rem_q     <= msg_len;
`ifdef TRV_HOST_TIMEOUT_EN
        err_q     <= 1'b0;
`endif
      end else begin
        case (state_q)
          LOAD_KEY: begin
            if (bit_cnt_q == '0) begin
              stb_key_q <= 1'b0;
              key_q     <= 1'b0;
              state_q   <= WAIT_INIT;
            end else begin
              key_q     <= key_sr_q[KEY_W-1];
              key_sr_q  <= {key_sr_q[KEY_W-2:0], 1'b0};
              bit_cnt_q <= bit_cnt_q - CNT_W'(1);
            end
          end

          WAIT_INIT: begin
            if (!SIGN_REG[1]) begin
              if (rem_q != '0) begin
                state_q    <= SEND;
                pt_ready_q <= 1'b1;
              end else begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
`ifdef TRV_HOST_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
`endif
          end

          SEND: begin
            if (pt_valid && pt_ready_q) begin
              data_q     <= pt_data;
              stb_data_q <= 1'b1;
              pt_ready_q <= 1'b0;
              state_q    <= WAIT_RES;
            end
          end

          WAIT_RES: begin
            if (SIGN_REG[0]) begin
              read_q     <= 1'b1;
              ct_data_q  <= DATA_OUT;
              ct_valid_q <= 1'b1;
              state_q    <= OUT;
            end
`ifdef TRV_HOST_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
              state_q <= ERR;
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
`endif
          end

          OUT: begin
            if (ct_ready) begin
              ct_valid_q <= 1'b0;
              rem_q      <= rem_q - LEN_W'(1);
              if (rem_q == LEN_W'(1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                pt_ready_q <= 1'b1;
                state_q    <= SEND;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign pt_ready = pt_ready_q;
  assign ct_data  = ct_data_q;
  assign ct_valid = ct_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign KEY      = key_q;
  assign STB_KEY  = stb_key_q;
  assign DATA     = data_q;
  assign STB_DATA = stb_data_q;
  assign READ     = read_q;
`ifdef TRV_HOST_TIMEOUT_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_trivium_host_ctrl.sv
// Scoreboard bench for trivium_host_ctrl: a behavioural core model answers each pushed byte with
// DATA ^ 8'hFF ^ byte_index; expected key bits, core bytes and ciphertext are queued at stimulus time.
module tb_trivium_host_ctrl;

  localparam int KEY_W = 80;
  localparam int LEN_W = 16;
  localparam int TMO_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             start = 1'b0;
  logic [KEY_W-1:0] key_in = '0;
  logic [LEN_W-1:0] msg_len = '0;
  logic [7:0]       pt_data = '0;
  logic             pt_valid = 1'b0;
  logic             pt_ready;
  logic [7:0]       ct_data;
  logic             ct_valid;
  logic             ct_ready = 1'b0;
  logic             busy;
  logic             done;
  logic             err;
  logic             KEY;
  logic             STB_KEY;
  logic [7:0]       DATA;
  logic             STB_DATA;
  logic             READ;
  logic [7:0]       DATA_OUT = '0;
  logic [7:0]       SIGN_REG = '0;

  trivium_host_ctrl #(.KEY_W(KEY_W), .LEN_W(LEN_W), .TMO_W(TMO_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .key_in(key_in), .msg_len(msg_len),
    .pt_data(pt_data), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .ct_data(ct_data), .ct_valid(ct_valid), .ct_ready(ct_ready),
    .busy(busy), .done(done), .err(err),
    .KEY(KEY), .STB_KEY(STB_KEY), .DATA(DATA), .STB_DATA(STB_DATA), .READ(READ),
    .DATA_OUT(DATA_OUT), .SIGN_REG(SIGN_REG)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard queues
  logic       exp_key_q[$];
  logic [7:0] exp_data_q[$];
  logic [7:0] exp_ct_q[$];
  logic [7:0] pt_q[$];

  // Observation counters, written by the monitor
  int key_cnt, stb_cnt, read_cnt, done_cnt, busy_cnt, viol_cnt, unexp_cnt, ct_idx;
  int first_stb_cyc, last_stb_cyc, err_rise_cyc, start_cyc;
  logic [7:0] last_ct;

  // Stimulus knobs
  int bp_idx = -1;
  int bp_left = 0;
  int core_delay = -1;
  bit core_mute = 1'b0;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] outs();
    return {7'd0, pt_ready, ct_data, ct_valid, busy, done, err, KEY, STB_KEY, DATA, STB_DATA, READ};
  endfunction

  task automatic clear_counters();
    key_cnt = 0; stb_cnt = 0; read_cnt = 0; done_cnt = 0; busy_cnt = 0;
    viol_cnt = 0; unexp_cnt = 0; ct_idx = 0;
    first_stb_cyc = -1; last_stb_cyc = -1; err_rise_cyc = -1;
  endtask

  task automatic flush_queues();
    exp_key_q.delete(); exp_data_q.delete(); exp_ct_q.delete(); pt_q.delete();
  endtask

  function automatic logic [KEY_W-1:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  task automatic start_msg(input logic [KEY_W-1:0] key, input int len,
                           input bit fix_first, input logic [7:0] first_pt);
    logic [7:0] b;
    for (int i = KEY_W - 1; i >= 0; i--) exp_key_q.push_back(key[i]);
    for (int i = 0; i < len; i++) begin
      b = (i == 0 && fix_first) ? first_pt : 8'($urandom);
      pt_q.push_back(b);
      exp_data_q.push_back(b);
      exp_ct_q.push_back(b ^ 8'hFF ^ 8'(i));
    end
    clear_counters();
    @(posedge CLK); #1;
    start   = 1'b1;
    key_in  = key;
    msg_len = len[LEN_W-1:0];
    @(posedge CLK); #1;
    start     = 1'b0;
    start_cyc = cyc;
    key_in    = rand_key();
    msg_len   = 16'($urandom);
    check("err_cleared", err, 0);
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    flush_queues();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    clear_counters();
  endtask

  task automatic wait_msg(input int len);
    int budget;
    budget = 200 + len * 40;
    for (int i = 0; i < budget && done_cnt == 0; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    check("done_pulse", done_cnt, 1);
    if (done_cnt == 0) begin
      apply_reset();
      return;
    end
    check("key_strobes", key_cnt, KEY_W);
    check("stb_data_cnt", stb_cnt, len);
    check("read_cnt", read_cnt, len);
    check("ct_pending", exp_ct_q.size(), 0);
    check("busy_idle", busy, 0);
    check("protocol", viol_cnt + unexp_cnt, 0);
    if (len > 0) check("latency", (first_stb_cyc - start_cyc) >= KEY_W + 2, 1);
  endtask

  task automatic run_msg(input int len);
    start_msg(rand_key(), len, 1'b0, 8'h00);
    wait_msg(len);
  endtask

  task automatic idle_check(input string tag);
    clear_counters();
    repeat (100) @(posedge CLK);
    #1;
    check({tag, "_busy"}, busy_cnt, 0);
    check({tag, "_strobes"}, key_cnt + stb_cnt + read_cnt + done_cnt, 0);
  endtask

  // Plaintext source with random gaps
  initial begin : pt_driver
    bit hs;
    forever begin
      @(negedge CLK);
      hs = pt_valid && pt_ready;
      @(posedge CLK); #1;
      if (hs && pt_q.size() > 0) void'(pt_q.pop_front());
      if (pt_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        pt_valid = 1'b1;
        pt_data  = pt_q[0];
      end else begin
        pt_valid = 1'b0;
        pt_data  = 8'($urandom);
      end
    end
  end

  // Ciphertext sink: random ready, plus a directed stall on one byte
  initial begin : ct_driver
    forever begin
      @(posedge CLK); #1;
      if (ct_valid && ct_idx == bp_idx && bp_left > 0) begin
        ct_ready = 1'b0;
        bp_left--;
      end else begin
        ct_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Behavioural Trivium core: init busy after key load, answers each byte after a delay
  initial begin : core_model
    logic       prev_stb_key;
    logic       pend;
    logic [7:0] val;
    int         init_cnt, dly, idx;
    prev_stb_key = 1'b0; pend = 1'b0; val = '0; init_cnt = 0; dly = 0; idx = 0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        pend = 1'b0; init_cnt = 0; idx = 0; prev_stb_key = 1'b0;
        SIGN_REG = '0;
        continue;
      end
      SIGN_REG[7:2] = 6'($urandom);
      if (STB_KEY) begin
        idx  = 0;
        pend = 1'b0;
      end
      if (prev_stb_key && !STB_KEY) init_cnt = $urandom_range(0, 6);
      prev_stb_key = STB_KEY;
      SIGN_REG[1] = (init_cnt > 0);
      if (init_cnt > 0) init_cnt--;
      if (READ) begin
        pend        = 1'b0;
        SIGN_REG[0] = 1'b0;
        DATA_OUT    = 8'($urandom);
      end else if (STB_DATA) begin
        pend = 1'b1;
        val  = DATA ^ 8'hFF ^ 8'(idx);
        idx++;
        dly  = (core_delay >= 0) ? core_delay : $urandom_range(0, 8);
      end
      if (pend) begin
        if (!core_mute && dly == 0) begin
          SIGN_REG[0] = 1'b1;
          DATA_OUT    = val;
        end else begin
          SIGN_REG[0] = 1'b0;
          if (dly > 0) dly--;
        end
      end else begin
        SIGN_REG[0] = ($urandom_range(0, 7) == 0);
        DATA_OUT    = 8'($urandom);
      end
    end
  end

  // Monitor: pops and compares whenever the DUT presents something
  initial begin : monitor
    logic       prev_read, prev_ctv, prev_hs, prev_err;
    logic [7:0] prev_ctd;
    int         outstanding;
    prev_read = 1'b0; prev_ctv = 1'b0; prev_hs = 1'b0; prev_err = 1'b0; prev_ctd = '0;
    outstanding = 0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_read = 1'b0; prev_ctv = 1'b0; prev_hs = 1'b0; prev_err = 1'b0;
        outstanding = 0;
        continue;
      end
      if (busy) busy_cnt++;
      if (STB_KEY) begin
        key_cnt++;
        outstanding = 0;
        if (exp_key_q.size() == 0) unexp_cnt++;
        else check("key_bit", KEY, exp_key_q.pop_front());
      end
      if (STB_DATA) begin
        stb_cnt++;
        if (first_stb_cyc < 0) first_stb_cyc = cyc;
        last_stb_cyc = cyc;
        outstanding++;
        if (outstanding > 1) viol_cnt++;
        if (ct_valid) viol_cnt++;
        if (exp_data_q.size() == 0) unexp_cnt++;
        else check("core_data", DATA, exp_data_q.pop_front());
      end
      if (READ) begin
        read_cnt++;
        if (prev_read) viol_cnt++;
      end
      if (prev_ctv && !prev_hs && (!ct_valid || ct_data !== prev_ctd)) viol_cnt++;
      if (pt_ready && ct_valid) viol_cnt++;
      if (ct_valid && ct_ready) begin
        outstanding--;
        ct_idx++;
        last_ct = ct_data;
        if (exp_ct_q.size() == 0) unexp_cnt++;
        else check("ct_data", ct_data, exp_ct_q.pop_front());
      end
      if (done) done_cnt++;
      if (err && !prev_err) err_rise_cyc = cyc;
      prev_read = READ;
      prev_ctv  = ct_valid;
      prev_hs   = ct_valid && ct_ready;
      prev_ctd  = ct_data;
      prev_err  = err;
    end
  end

  initial begin : stimulus
    int len;
    clear_counters();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", outs(), 0);
    @(posedge CLK); #1 RST = 1'b0;
    idle_check("idle");

    // Known key with an empty message
    start_msg(80'hA5A5_0000_0000_0000_FF01, 0, 1'b0, 8'h00);
    wait_msg(0);

    // Single byte, result 5 cycles after the push
    core_delay = 5;
    start_msg(rand_key(), 1, 1'b1, 8'h3C);
    wait_msg(1);
    check("single_ct", last_ct, 8'hC3);
    core_delay = -1;

    // Back-pressure on the second byte
    bp_idx  = 1;
    bp_left = 10;
    start_msg(rand_key(), 3, 1'b0, 8'h00);
    wait_msg(3);
    check("bp_consumed", bp_left, 0);
    bp_idx = -1;

    for (int m = 0; m < 8; m++) begin
      len = $urandom_range(0, 6);
      run_msg(len);
    end
    run_msg(24);

    // Reset while the key is shifting
    start_msg(rand_key(), 2, 1'b0, 8'h00);
    repeat (20) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check("abort_outputs", outs(), 0);
    flush_queues();
    @(posedge CLK);
    @(posedge CLK); #1 RST = 1'b0;
    idle_check("post_abort");
    run_msg(3);

`ifdef TRV_HOST_TIMEOUT_EN
    // Core never answers: watchdog must trip 15 cycles into WAIT_RES
    core_mute = 1'b1;
    start_msg(rand_key(), 1, 1'b0, 8'h00);
    for (int i = 0; i < 400 && err_rise_cyc < 0; i++) @(posedge CLK);
    #1;
    check("tmo_err", err, 1);
    check("tmo_cycles", err_rise_cyc - last_stb_cyc, 15);
    check("err_busy", busy, 0);
    repeat (5) @(posedge CLK);
    #1;
    check("err_hold", err, 1);
    check("err_stb_data", stb_cnt, 1);
    check("err_read", read_cnt, 0);
    flush_queues();
    core_mute = 1'b0;
    run_msg(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
